// File: rtl/fft_sched_pkg.sv
// Shared encodings for the FFT frame scheduler: FSM states, transform modes, frame length.
package fft_sched_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CFG    = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    localparam logic FFT_FWD = 1'b1;
    localparam logic FFT_INV = 1'b0;

    function automatic int unsigned fft_len(input int unsigned log2_len);
        return 32'd1 << log2_len;
    endfunction

endpackage

// File: rtl/fft_sched_rr_arb.sv
// Two-way round-robin arbiter; ptr names the requester favoured under contention.
module fft_sched_rr_arb (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Shares one burst FFT core between two requesters: per-frame round-robin grant,
// config write, FFT_LEN-sample stream with generated tlast, then wait for output tlast.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int unsigned LOG2_FFT_LEN = 10,
    parameter int unsigned DATA_WIDTH   = 16
) (
    input  logic                    i_aclk,
    input  logic                    i_rstn,
    input  logic [1:0]              i_req_start,
    input  logic [1:0]              i_req_mode,
    input  logic [1:0]              i_req_tvalid,
    input  logic [4*DATA_WIDTH-1:0] i_req_tdata,
    output logic [1:0]              o_req_tready,
    output logic [1:0]              o_grant,
    output logic                    o_fft_cfg_tvalid,
    output logic                    o_fft_cfg_tdata,
    output logic                    o_fft_tvalid,
    output logic [2*DATA_WIDTH-1:0] o_fft_tdata,
    output logic                    o_fft_tlast,
    input  logic                    i_fft_tready,
    input  logic                    i_fft_stat,
    input  logic [2:0]              i_fft_alm,
    input  logic                    i_fft_out_tvalid,
    input  logic                    i_fft_out_tlast,
    output logic [1:0]              o_done,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int unsigned SW      = 2 * DATA_WIDTH;
    localparam int unsigned FFT_LEN = fft_len(LOG2_FFT_LEN);
    localparam logic [LOG2_FFT_LEN-1:0] CNT_LAST = LOG2_FFT_LEN'(FFT_LEN - 1);

    logic [1:0]              state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    mode_q, mode_d;
    logic                    ptr_q, ptr_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              done_q, done_d;
    logic                    err_q, err_d;
    logic [LOG2_FFT_LEN-1:0] cnt_q, cnt_d;

    logic [1:0]    win;
    logic          streaming;
    logic          beat;
    logic          last_cnt;
    logic [SW-1:0] owner_data;

    fft_sched_rr_arb u_arb (
        .req   (i_req_start),
        .ptr   (ptr_q),
        .grant (win)
    );

    assign streaming  = (state_q == STREAM);
    assign owner_data = owner_q ? i_req_tdata[2*SW-1:SW] : i_req_tdata[SW-1:0];
    assign last_cnt   = (cnt_q == CNT_LAST);
    assign beat       = o_fft_tvalid & i_fft_tready;

    always_comb begin
        o_fft_tvalid     = streaming & (owner_q ? i_req_tvalid[1] : i_req_tvalid[0]);
        o_fft_tdata      = streaming ? owner_data : '0;
        o_fft_tlast      = o_fft_tvalid & last_cnt;
        // grant_q is one-hot on the owner, so it doubles as the tready steering mask
        o_req_tready     = streaming ? (grant_q & {2{i_fft_tready}}) : 2'b00;
        o_fft_cfg_tvalid = (state_q == CFG);
        o_fft_cfg_tdata  = (mode_q == FFT_FWD);
        o_grant          = grant_q;
        o_done           = done_q;
        o_busy           = (state_q != IDLE);
        o_err            = err_q;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        done_d  = 2'b00;
        err_d   = err_q | (|i_fft_alm);
        unique case (state_q)
            IDLE: begin
                // A set i_fft_stat means the core still holds a partial frame: no cfg write
                if ((|i_req_start) && !i_fft_stat) begin
                    grant_d = win;
                    owner_d = win[1];
                    mode_d  = win[1] ? i_req_mode[1] : i_req_mode[0];
                    state_d = CFG;
                end
            end
            CFG: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (beat) begin
                    if (last_cnt) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (i_fft_out_tvalid && i_fft_out_tlast) begin
                    done_d  = grant_q;
                    grant_d = 2'b00;
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            mode_q  <= FFT_INV;
            ptr_q   <= 1'b0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with a beat scoreboard on the FFT input stream.
module tb_fft_frame_scheduler;
    import fft_sched_pkg::*;

    localparam int LEN = 1024;
    localparam int SW  = 32;

    logic          i_aclk;
    logic          i_rstn;
    logic [1:0]    i_req_start;
    logic [1:0]    i_req_mode;
    logic [1:0]    i_req_tvalid;
    logic [63:0]   i_req_tdata;
    logic [1:0]    o_req_tready;
    logic [1:0]    o_grant;
    logic          o_fft_cfg_tvalid;
    logic          o_fft_cfg_tdata;
    logic          o_fft_tvalid;
    logic [SW-1:0] o_fft_tdata;
    logic          o_fft_tlast;
    logic          i_fft_tready;
    logic          i_fft_stat;
    logic [2:0]    i_fft_alm;
    logic          i_fft_out_tvalid;
    logic          i_fft_out_tlast;
    logic [1:0]    o_done;
    logic          o_busy;
    logic          o_err;

    fft_frame_scheduler #(
        .LOG2_FFT_LEN (10),
        .DATA_WIDTH   (16)
    ) dut (
        .i_aclk           (i_aclk),
        .i_rstn           (i_rstn),
        .i_req_start      (i_req_start),
        .i_req_mode       (i_req_mode),
        .i_req_tvalid     (i_req_tvalid),
        .i_req_tdata      (i_req_tdata),
        .o_req_tready     (o_req_tready),
        .o_grant          (o_grant),
        .o_fft_cfg_tvalid (o_fft_cfg_tvalid),
        .o_fft_cfg_tdata  (o_fft_cfg_tdata),
        .o_fft_tvalid     (o_fft_tvalid),
        .o_fft_tdata      (o_fft_tdata),
        .o_fft_tlast      (o_fft_tlast),
        .i_fft_tready     (i_fft_tready),
        .i_fft_stat       (i_fft_stat),
        .i_fft_alm        (i_fft_alm),
        .i_fft_out_tvalid (i_fft_out_tvalid),
        .i_fft_out_tlast  (i_fft_out_tlast),
        .o_done           (o_done),
        .o_busy           (o_busy),
        .o_err            (o_err)
    );

    initial i_aclk = 1'b0;
    always #5 i_aclk = ~i_aclk;

    typedef struct packed {
        logic [SW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("%s observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {o_grant, o_busy, o_fft_cfg_tvalid, o_fft_cfg_tdata, o_fft_tvalid,
                    o_fft_tlast, o_req_tready, o_done, o_err}, 64'd0);
        check({tag, " tdata"}, o_fft_tdata, 64'd0);
    endtask

    task automatic grant_expect(input logic [1:0] g, input logic mode);
        check("grant", o_grant, g);
        check("cfg_tvalid", o_fft_cfg_tvalid, 1);
        check("cfg_tdata", o_fft_cfg_tdata, mode);
        check("busy at grant", o_busy, 1);
    endtask

    // Streams one frame from requester own; stops early once abort_at beats have moved.
    task automatic run_frame(input int own, input int pv, input int pr, input logic [15:0] tag16,
                             input int abort_at);
        int    sent   = 0;
        int    pushed = 0;
        int    bad    = 0;
        logic  vld, rdy;
        logic [1:0] oh;
        beat_t b;
        oh = (own == 1) ? 2'b10 : 2'b01;
        for (int c = 0; c < 20000 && sent < LEN; c++) begin
            if (sent == abort_at) break;
            cyc();
            vld = ($urandom_range(99) < pv);
            rdy = ($urandom_range(99) < pr);
            i_req_tvalid           = 2'b11;
            i_req_tvalid[own]      = vld;
            i_fft_tready           = rdy;
            i_req_tdata            = {32'hdead_beef, 32'hdead_beef};
            i_req_tdata[own*SW +: SW] = {tag16, 16'(sent)};
            if (vld && pushed == sent) begin
                sb.push_back('{data: {tag16, 16'(sent)}, last: (sent == LEN - 1)});
                pushed++;
            end
            settle();
            if (o_fft_tvalid !== vld || o_grant !== oh ||
                o_fft_tlast !== (vld && sent == LEN - 1) ||
                o_req_tready !== (rdy ? oh : 2'b00)) bad++;
            if (vld && rdy) begin
                b = sb.pop_front();
                check("beat data", o_fft_tdata, b.data);
                check("beat last", o_fft_tlast, b.last);
                sent++;
            end
        end
        check("stream ctl/tready cycles", bad, 0);
        if (abort_at < 0) begin
            check("frame beats", sent, LEN);
            check("scoreboard empty", sb.size(), 0);
        end else begin
            check("beats before abort", sent, abort_at);
            sb.delete();
        end
    endtask

    task automatic finish_frame(input logic [1:0] g, input logic inj_alm);
        cyc();
        i_req_tvalid = 2'b11;
        i_fft_tready = 1'b1;
        i_fft_alm    = inj_alm ? 3'b010 : 3'b000;
        settle();
        check("drain busy", o_busy, 1);
        check("drain grant", o_grant, g);
        check("drain quiet", {o_fft_tvalid, o_fft_tlast, o_req_tready, o_done}, 0);
        i_fft_out_tvalid = 1'b1;
        i_fft_out_tlast  = 1'b0;
        cyc();
        i_fft_alm = 3'b000;
        settle();
        if (inj_alm) check("err after alarm", o_err, 1);
        check("drain ignores non-last", {o_busy, o_done}, 3'b100);
        i_fft_out_tlast = 1'b1;
        cyc();
        i_fft_out_tvalid = 1'b0;
        i_fft_out_tlast  = 1'b0;
        i_req_tvalid     = 2'b00;
        settle();
        check("done pulse", o_done, g);
        check("idle after done", {o_busy, o_grant}, 0);
        cyc();
        settle();
        check("done one cycle", o_done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        i_rstn = 1'b0;
        i_req_start = '0; i_req_mode = '0; i_req_tvalid = '0; i_req_tdata = '0;
        i_fft_tready = 1'b0; i_fft_stat = 1'b0; i_fft_alm = '0;
        i_fft_out_tvalid = 1'b0; i_fft_out_tlast = 1'b0;
        #2;
        check_all_zero("reset outputs");
        repeat (3) cyc();
        #2 i_rstn = 1'b1;

        // Single requester 0, forward, full rate
        cyc();
        i_req_start = 2'b01; i_req_mode = {1'b0, FFT_FWD};
        settle();
        check("no grant before edge", o_grant, 0);
        cyc();
        settle();
        grant_expect(2'b01, 1'b1);
        i_req_start = 2'b00;
        run_frame(0, 100, 100, 16'h00a0, -1);
        finish_frame(2'b01, 1'b0);

        // Contention straight after reset: 0, then 1, then 0 again
        i_rstn = 1'b0;
        cyc();
        #2 i_rstn = 1'b1;
        cyc();
        i_req_start = 2'b11; i_req_mode = 2'b01;
        cyc();
        settle();
        grant_expect(2'b01, 1'b1);
        i_req_start = 2'b10;
        run_frame(0, 100, 100, 16'h00b0, -1);
        finish_frame(2'b01, 1'b0);
        grant_expect(2'b10, 1'b0);
        i_req_start = 2'b00;
        run_frame(1, 100, 100, 16'h01b1, -1);
        finish_frame(2'b10, 1'b0);
        i_req_start = 2'b11; i_req_mode = 2'b11;
        cyc();
        settle();
        grant_expect(2'b01, 1'b1);
        i_req_start = 2'b00;

        // Random backpressure on both sides, alarm pulse during drain
        run_frame(0, 70, 70, 16'h00c0, -1);
        finish_frame(2'b01, 1'b1);

        // Core status holds off grant and cfg
        i_fft_stat = 1'b1; i_req_start = 2'b10; i_req_mode = 2'b10;
        for (int k = 0; k < 3; k++) begin
            cyc();
            settle();
            check("stat holds off", {o_grant, o_fft_cfg_tvalid, o_busy}, 0);
        end
        i_fft_stat = 1'b0;
        cyc();
        settle();
        grant_expect(2'b10, 1'b1);
        check("err sticky across frame", o_err, 1);
        i_req_start = 2'b00;

        // Asynchronous reset part-way through a frame
        run_frame(1, 100, 100, 16'h01d1, 500);
        check("err still set before reset", o_err, 1);
        #1 i_rstn = 1'b0;
        #1;
        check_all_zero("mid-frame reset");
        i_req_tvalid = 2'b00; i_fft_tready = 1'b0;
        repeat (2) cyc();
        #2 i_rstn = 1'b1;
        cyc();
        i_req_start = 2'b01; i_req_mode = 2'b00;
        cyc();
        settle();
        grant_expect(2'b01, 1'b0);
        i_req_start = 2'b00;
        run_frame(0, 100, 100, 16'h00e0, -1);
        finish_frame(2'b01, 1'b0);
        check("err clear after reset", o_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
